// File: rtl/led_cmd_if.sv
// Byte-wide command channel into the LED counter controller (valid/ready handshake).
interface led_cmd_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/led_counter_ctrl.sv
// LED counter with a byte command parser: run/pause/clear/load/speed/direction
// control over a free-running half-period timer.
module led_counter_ctrl #(
  parameter int unsigned CLK_FREQ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  led_cmd_if.slave   cmd,
  output logic [7:0] leds,
  output logic       running,
  output logic       cmd_err
);

  localparam logic [31:0] BASE = 32'(CLK_FREQ / 2);

  localparam logic [7:0] OP_RUN   = 8'h01;
  localparam logic [7:0] OP_PAUSE = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;
  localparam logic [7:0] OP_LOAD  = 8'h04;
  localparam logic [7:0] OP_SPEED = 8'h05;
  localparam logic [7:0] OP_DIR   = 8'h06;

  typedef enum logic [1:0] {OPC, OPND, EXEC} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  opcode_reg, opcode_next;
  logic [7:0]  operand_reg, operand_next;
  logic        cmd_err_reg, cmd_err_next;
  logic [7:0]  leds_reg, leds_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        running_reg, running_next;
  logic        dir_reg, dir_next;
  logic [2:0]  shift_reg, shift_next;

  logic        xfer;
  logic        exec;
  logic        advance;
  logic [31:0] period;

  assign cmd.cmd_ready = (state_reg != EXEC);
  assign xfer          = cmd.cmd_valid && cmd.cmd_ready;
  assign exec          = (state_reg == EXEC);

  // Shifting past the base half-period clamps to a one-cycle period.
  assign period  = ((BASE >> shift_reg) == 32'd0) ? 32'd1 : (BASE >> shift_reg);
  // A PAUSE being executed freezes the counter in the same cycle.
  assign advance = running_reg && !(exec && opcode_reg == OP_PAUSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= OPC;
      opcode_reg  <= 8'h00;
      operand_reg <= 8'h00;
      cmd_err_reg <= 1'b0;
      leds_reg    <= 8'h00;
      cnt_reg     <= 32'd0;
      running_reg <= 1'b1;
      dir_reg     <= 1'b1;
      shift_reg   <= 3'd0;
    end else begin
      state_reg   <= state_next;
      opcode_reg  <= opcode_next;
      operand_reg <= operand_next;
      cmd_err_reg <= cmd_err_next;
      leds_reg    <= leds_next;
      cnt_reg     <= cnt_next;
      running_reg <= running_next;
      dir_reg     <= dir_next;
      shift_reg   <= shift_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    opcode_next  = opcode_reg;
    operand_next = operand_reg;
    cmd_err_next = 1'b0;
    case (state_reg)
      OPC: begin
        if (xfer) begin
          case (cmd.cmd_data)
            OP_RUN, OP_PAUSE, OP_CLEAR: begin
              opcode_next = cmd.cmd_data;
              state_next  = EXEC;
            end
            OP_LOAD, OP_SPEED, OP_DIR: begin
              opcode_next = cmd.cmd_data;
              state_next  = OPND;
            end
            default: cmd_err_next = 1'b1;
          endcase
        end
      end
      OPND: begin
        if (xfer) begin
          operand_next = cmd.cmd_data;
          state_next   = EXEC;
        end
      end
      EXEC:    state_next = OPC;
      default: state_next = OPC;
    endcase
  end

  always_comb begin
    leds_next    = leds_reg;
    cnt_next     = cnt_reg;
    running_next = running_reg;
    dir_next     = dir_reg;
    shift_next   = shift_reg;

    if (advance) begin
      if (cnt_reg == period - 32'd1) begin
        cnt_next  = 32'd0;
        leds_next = dir_reg ? leds_reg + 8'd1 : leds_reg - 8'd1;
      end else begin
        cnt_next = cnt_reg + 32'd1;
      end
    end

    // Commands override any step landing on the same edge.
    if (exec) begin
      case (opcode_reg)
        OP_RUN:   running_next = 1'b1;
        OP_PAUSE: running_next = 1'b0;
        OP_CLEAR: begin
          leds_next = 8'h00;
          cnt_next  = 32'd0;
        end
        OP_LOAD: begin
          leds_next = operand_reg;
          cnt_next  = 32'd0;
        end
        OP_SPEED: begin
          shift_next = operand_reg[2:0];
          cnt_next   = 32'd0;
        end
        OP_DIR:   dir_next = operand_reg[0];
        default:  ;
      endcase
    end
  end

  assign leds    = leds_reg;
  assign running = running_reg;
  assign cmd_err = cmd_err_reg;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Randomized + directed bench for led_counter_ctrl against a byte-stream command model.
module tb_led_counter_ctrl;

  localparam int unsigned CLK_FREQ = 8;
  localparam int unsigned BASE     = CLK_FREQ / 2;

  logic       clk;
  logic       rst_n;
  logic [7:0] leds;
  logic       running;
  logic       cmd_err;

  led_cmd_if bus ();

  led_counter_ctrl #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (bus.slave),
    .leds    (leds),
    .running (running),
    .cmd_err (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  m_leds;
  int unsigned m_cnt;
  bit          m_run;
  bit          m_dir;
  int unsigned m_shift;
  bit          m_err;
  bit          m_pend;
  logic [7:0]  m_op;
  logic [7:0]  m_arg;
  logic [7:0]  m_buf[$];
  bit          m_last_xfer;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cmd_len(input logic [7:0] op);
    if (op >= 8'h01 && op <= 8'h03) return 1;
    if (op >= 8'h04 && op <= 8'h06) return 2;
    return 0;
  endfunction

  function automatic int unsigned half_period();
    int unsigned p = BASE >> m_shift;
    return (p == 0) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_leds = 8'h00; m_cnt = 0; m_run = 1; m_dir = 1; m_shift = 0;
    m_err = 0; m_pend = 0; m_op = 8'h00; m_arg = 8'h00; m_last_xfer = 0;
    m_buf.delete();
  endtask

  // One rising edge of the specified behaviour, using the inputs held across it.
  task automatic model_update();
    bit          xfer     = bus.cmd_valid && !m_pend;
    bit          do_cmd   = m_pend;
    bit          step_ok  = m_run && !(m_pend && m_op == 8'h02);
    logic [7:0]  nl       = m_leds;
    int unsigned nc       = m_cnt;
    int          len;

    if (step_ok) begin
      if (m_cnt + 1 == half_period()) begin
        nc = 0;
        nl = m_dir ? m_leds + 8'd1 : m_leds - 8'd1;
      end else begin
        nc = m_cnt + 1;
      end
    end
    m_leds = nl;
    m_cnt  = nc;

    if (do_cmd) begin
      case (m_op)
        8'h01: m_run = 1;
        8'h02: m_run = 0;
        8'h03: begin m_leds = 8'h00; m_cnt = 0; end
        8'h04: begin m_leds = m_arg; m_cnt = 0; end
        8'h05: begin m_shift = m_arg % 8; m_cnt = 0; end
        8'h06: m_dir = m_arg[0];
        default: ;
      endcase
      m_pend = 0;
    end

    m_err = 0;
    m_last_xfer = xfer;
    if (xfer) begin
      m_buf.push_back(bus.cmd_data);
      len = cmd_len(m_buf[0]);
      if (len == 0) begin
        m_err = 1;
        m_buf.delete();
      end else if (m_buf.size() == len) begin
        m_pend = 1;
        m_op   = m_buf[0];
        m_arg  = (len == 2) ? m_buf[1] : 8'h00;
        m_buf.delete();
      end
    end
  endtask

  task automatic compare_all();
    check("leds",      leds,          m_leds);
    check("running",   running,       m_run);
    check("cmd_err",   cmd_err,       m_err);
    check("cmd_ready", bus.cmd_ready, !m_pend);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit got_it = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
    for (int i = 0; i < 4 && !got_it; i++) begin
      tick();
      got_it = m_last_xfer;
    end
    bus.cmd_valid = 1'b0;
    check("xfer_timeout", got_it, 1);
    $display("byte %02h sent leds=%02h running=%0d t=%0t", b, leds, running, $time);
  endtask

  // Asserted mid-cycle so the response can only come from the asynchronous path.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset pulse done t=%0t", $time);
  endtask

  initial begin
    logic [7:0] d;
    int r;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free run through 0xFF -> 0x00
    idle(1030);

    send_byte(8'h04); send_byte(8'hA5);
    idle(10);

    send_byte(8'h06); send_byte(8'h00);
    send_byte(8'h04); send_byte(8'h00);
    idle(10);

    send_byte(8'h02);
    idle(20);
    send_byte(8'h01);
    idle(10);

    send_byte(8'h06); send_byte(8'h01);
    send_byte(8'h05); send_byte(8'h02);
    idle(8);
    send_byte(8'h05); send_byte(8'h07);
    idle(8);
    send_byte(8'h05); send_byte(8'h00);
    idle(6);

    send_byte(8'h7E);
    idle(3);

    send_byte(8'h04);
    async_reset();
    send_byte(8'h03);
    idle(10);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5)      d = 8'(r + 1);
      else if (r == 7) d = 8'h00;
      else if (r == 8) d = 8'h7E;
      else             d = 8'($urandom);
      bus.cmd_valid = ($urandom_range(0, 99) < 35);
      bus.cmd_data  = d;
      tick();
    end
    bus.cmd_valid = 1'b0;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
